// File: rtl/game_move_ctrl.sv
// rtl/game_move_ctrl.sv - Sokoban move controller feeding the 3-deep undo/history stage
// Computes man/box move candidates and pulses the history stage enable with the matching sel.
module game_move_ctrl #(
    parameter int N        = 134,
    parameter int GRID     = 8,
    parameter int UNDO_MAX = 3,
    parameter int STEP_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [1:0]        key_dir,
    input  logic              key_undo,
    input  logic              key_restart,
    input  logic [N-1:0]      game_state,
    output logic [N-1:0]      game_state_mm,
    output logic [N-1:0]      game_state_bm,
    output logic [1:0]        sel,
    output logic              game_state_en,
    output logic              busy,
    output logic              move_reject,
    output logic [1:0]        undo_left,
    output logic [STEP_W-1:0] steps
);

    localparam int PW = 6;

    typedef enum logic [2:0] {BOOT, LOAD, IDLE, CALC, COMMIT, SETTLE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [1:0]        dir_q;
    logic [PW-1:0]     man;
    logic [63:0]       wall_map;
    logic [63:0]       box_map;
    logic [PW:0]       s1;
    logic [PW:0]       s2;
    logic [PW-1:0]     t1;
    logic [PW-1:0]     t2;
    logic              pushes_box;
    logic              accept;
    logic [63:0]       bit_t1;
    logic [63:0]       bit_t2;

    // Returns {in_grid, target}; edge rules reject row wrap and leaving rows 0..GRID-1.
    function automatic logic [PW:0] step_cell(input logic [PW-1:0] pos, input logic [1:0] dir);
        int   row;
        int   col;
        logic ok;
        row = int'(pos) / GRID;
        col = int'(pos) % GRID;
        case (dir)
            2'b00:   begin ok = (row != 0);        row = row - 1; end
            2'b01:   begin ok = (row != GRID - 1); row = row + 1; end
            2'b10:   begin ok = (col != 0);        col = col - 1; end
            default: begin ok = (col != GRID - 1); col = col + 1; end
        endcase
        return {ok, PW'(row * GRID + col)};
    endfunction

    assign man        = game_state[133:128];
    assign wall_map   = game_state[127:64];
    assign box_map    = game_state[63:0];
    assign s1         = step_cell(man, dir_q);
    assign t1         = s1[PW-1:0];
    assign s2         = step_cell(t1, dir_q);
    assign t2         = s2[PW-1:0];
    assign bit_t1     = 64'd1 << t1;
    assign bit_t2     = 64'd1 << t2;
    assign pushes_box = box_map[t1];
    assign accept     = s1[PW] && !wall_map[t1] &&
                        (!pushes_box || (s2[PW] && !wall_map[t2] && !box_map[t2]));

    assign game_state_en = (state == LOAD) || (state == COMMIT);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:   state_nx = LOAD;
            LOAD:   state_nx = SETTLE;
            SETTLE: state_nx = IDLE;
            COMMIT: state_nx = SETTLE;
            CALC:   state_nx = accept ? COMMIT : IDLE;
            IDLE: begin
                if (key_valid) begin
                    if (key_restart)            state_nx = LOAD;
                    else if (key_undo)          state_nx = (undo_left != 2'd0) ? COMMIT : IDLE;
                    else                        state_nx = CALC;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_state_mm <= '0;
            game_state_bm <= '0;
            sel           <= 2'd0;
            move_reject   <= 1'b0;
            undo_left     <= 2'd0;
            steps         <= '0;
            dir_q         <= 2'd0;
        end else begin
            move_reject <= 1'b0;
            case (state)
                BOOT: sel <= 2'd0;
                IDLE: begin
                    if (key_valid) begin
                        if (key_restart) begin
                            sel       <= 2'd0;
                            undo_left <= 2'd0;
                            steps     <= '0;
                        end else if (key_undo) begin
                            if (undo_left != 2'd0) sel <= 2'd3;
                            else                   move_reject <= 1'b1;
                        end else begin
                            dir_q <= key_dir;
                        end
                    end
                end
                CALC: begin
                    if (!accept) begin
                        move_reject <= 1'b1;
                    end else if (pushes_box) begin
                        game_state_bm <= {t1, wall_map, (box_map & ~bit_t1) | bit_t2};
                        sel           <= 2'd1;
                    end else begin
                        game_state_mm <= {t1, wall_map, box_map};
                        sel           <= 2'd2;
                    end
                end
                COMMIT: begin
                    // sel still tells which kind of commit is in flight
                    if (sel == 2'd3) begin
                        if (undo_left != 2'd0) undo_left <= undo_left - 2'd1;
                        if (steps != '0)       steps     <= steps - STEP_W'(1);
                    end else begin
                        if (undo_left != 2'(UNDO_MAX)) undo_left <= undo_left + 2'd1;
                        if (steps != {STEP_W{1'b1}})   steps     <= steps + STEP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_move_ctrl.sv
// tb/tb_game_move_ctrl.sv - randomized bench for game_move_ctrl against a grid-level model
// The bench also plays the history stage, feeding the modelled committed state back.
module tb_game_move_ctrl;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [1:0]   key_dir;
    logic         key_undo;
    logic         key_restart;
    logic [133:0] game_state;
    logic [133:0] game_state_mm;
    logic [133:0] game_state_bm;
    logic [1:0]   sel;
    logic         game_state_en;
    logic         busy;
    logic         move_reject;
    logic [1:0]   undo_left;
    logic [9:0]   steps;

    game_move_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_dir(key_dir),
        .key_undo(key_undo), .key_restart(key_restart), .game_state(game_state),
        .game_state_mm(game_state_mm), .game_state_bm(game_state_bm), .sel(sel),
        .game_state_en(game_state_en), .busy(busy), .move_reject(move_reject),
        .undo_left(undo_left), .steps(steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [1:0]   sel;
        logic [133:0] data;
        logic         busy;
        logic         rej;
        logic [1:0]   ul;
        logic [9:0]   st;
        int           lit_man;
        int           lit_st;
    } rec_t;

    rec_t         q[$];
    logic [133:0] hist[$];
    logic [133:0] m_state;
    logic [133:0] level;
    logic [9:0]   m_steps;
    int           checks;
    int           failures;

    function automatic rec_t mk(input logic en, input logic [1:0] s, input logic [133:0] d,
                                input logic b, input logic rj, input logic [1:0] ul,
                                input logic [9:0] st);
        rec_t r;
        r.en = en; r.sel = s; r.data = d; r.busy = b; r.rej = rj; r.ul = ul; r.st = st;
        r.lit_man = -1; r.lit_st = -1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Move rules on a 2-D grid: man steps once, a box in the way is pushed one further cell.
    task automatic model_move(input logic [133:0] s, input logic [1:0] d, output bit ok,
                              output logic [1:0] nsel, output logic [133:0] ns);
        int r, c, dr, dc, r1, c1, r2, c2, i1, i2;
        r = int'(s[133:128]) / 8;
        c = int'(s[133:128]) % 8;
        dr = 0; dc = 0;
        case (d)
            2'b00:   dr = -1;
            2'b01:   dr = 1;
            2'b10:   dc = -1;
            default: dc = 1;
        endcase
        ok = 0; nsel = 2'd0; ns = s;
        r1 = r + dr; c1 = c + dc;
        if (r1 < 0 || r1 > 7 || c1 < 0 || c1 > 7) return;
        i1 = r1 * 8 + c1;
        if (s[64 + i1]) return;
        if (s[i1]) begin
            r2 = r1 + dr; c2 = c1 + dc;
            if (r2 < 0 || r2 > 7 || c2 < 0 || c2 > 7) return;
            i2 = r2 * 8 + c2;
            if (s[64 + i2] || s[i2]) return;
            ns[i1] = 1'b0;
            ns[i2] = 1'b1;
            nsel = 2'd1;
        end else begin
            nsel = 2'd2;
        end
        ns[133:128] = 6'(i1);
        ok = 1;
    endtask

    always @(negedge clk) begin
        rec_t r;
        logic [133:0] v;
        if (rst) begin
            chk("rst_en", 134'(game_state_en), '0);
            chk("rst_busy", 134'(busy), 134'(1));
            chk("rst_rej", 134'(move_reject), '0);
            chk("rst_sel", 134'(sel), '0);
            chk("rst_undo_left", 134'(undo_left), '0);
            chk("rst_steps", 134'(steps), '0);
            chk("rst_mm", game_state_mm, '0);
            chk("rst_bm", game_state_bm, '0);
        end else begin
            if (q.size() > 0) r = q.pop_front();
            else r = mk(1'b0, 2'd0, '0, 1'b0, 1'b0, 2'(hist.size()), m_steps);
            chk("en", 134'(game_state_en), 134'(r.en));
            chk("busy", 134'(busy), 134'(r.busy));
            chk("move_reject", 134'(move_reject), 134'(r.rej));
            chk("undo_left", 134'(undo_left), 134'(r.ul));
            chk("steps", 134'(steps), 134'(r.st));
            if (r.en) begin
                chk("sel", 134'(sel), 134'(r.sel));
                if (r.sel == 2'd1) chk("bm", game_state_bm, r.data);
                if (r.sel == 2'd2) chk("mm", game_state_mm, r.data);
            end
            if (r.lit_man >= 0) begin
                v = (r.sel == 2'd1) ? game_state_bm : game_state_mm;
                chk("pin_man_dut", 134'(v[133:128]), 134'(r.lit_man));
                chk("pin_man_model", 134'(r.data[133:128]), 134'(r.lit_man));
            end
            if (r.lit_st >= 0) begin
                chk("pin_steps_dut", 134'(steps), 134'(r.lit_st));
                chk("pin_steps_model", 134'(r.st), 134'(r.lit_st));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        game_state = m_state;
    endtask

    task automatic do_reset(input logic [133:0] lv);
        q.delete();
        rst = 1'b1;
        key_valid = 1'b0; key_undo = 1'b0; key_restart = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        level = lv; m_state = lv; hist.delete(); m_steps = '0;
        game_state = lv;
        rst = 1'b0;
        q.push_back(mk(1'b0, 2'd0, '0, 1'b1, 1'b0, 2'd0, 10'd0));
        q.push_back(mk(1'b1, 2'd0, '0, 1'b1, 1'b0, 2'd0, 10'd0));
        q.push_back(mk(1'b0, 2'd0, '0, 1'b1, 1'b0, 2'd0, 10'd0));
        wait_idle();
    endtask

    task automatic key(input bit u, input bit rs, input logic [1:0] d, input bit extra,
                       input int pin_man, input int pin_st);
        rec_t         r0;
        bit           ok;
        bit           longop;
        logic [1:0]   s;
        logic [133:0] ns;
        logic [1:0]   ul;
        logic [1:0]   nul;
        logic [9:0]   st;
        logic [9:0]   nst;
        ul = 2'(hist.size()); st = m_steps; longop = 0;
        q.push_back(mk(1'b0, 2'd0, '0, 1'b0, 1'b0, ul, st));
        if (rs) begin
            q.push_back(mk(1'b1, 2'd0, '0, 1'b1, 1'b0, 2'd0, 10'd0));
            q.push_back(mk(1'b0, 2'd0, '0, 1'b1, 1'b0, 2'd0, 10'd0));
            hist.delete(); m_state = level; m_steps = '0; longop = 1;
        end else if (u) begin
            if (hist.size() > 0) begin
                nst = (st != 10'd0) ? st - 10'd1 : 10'd0;
                q.push_back(mk(1'b1, 2'd3, '0, 1'b1, 1'b0, ul, st));
                q.push_back(mk(1'b0, 2'd0, '0, 1'b1, 1'b0, ul - 2'd1, nst));
                m_state = hist.pop_back(); m_steps = nst; longop = 1;
            end else begin
                q.push_back(mk(1'b0, 2'd0, '0, 1'b0, 1'b1, ul, st));
            end
        end else begin
            model_move(m_state, d, ok, s, ns);
            q.push_back(mk(1'b0, 2'd0, '0, 1'b1, 1'b0, ul, st));
            if (ok) begin
                nul = (ul == 2'd3) ? 2'd3 : ul + 2'd1;
                nst = (st == 10'd1023) ? st : st + 10'd1;
                r0 = mk(1'b1, s, ns, 1'b1, 1'b0, ul, st);
                r0.lit_man = pin_man;
                q.push_back(r0);
                r0 = mk(1'b0, 2'd0, '0, 1'b1, 1'b0, nul, nst);
                r0.lit_st = pin_st;
                q.push_back(r0);
                hist.push_back(m_state);
                if (hist.size() > 3) void'(hist.pop_front());
                m_state = ns; m_steps = nst; longop = 1;
            end else begin
                q.push_back(mk(1'b0, 2'd0, '0, 1'b0, 1'b1, ul, st));
            end
        end
        key_valid = 1'b1; key_undo = u; key_restart = rs; key_dir = d;
        @(posedge clk); #1;
        key_valid = 1'b0; key_undo = 1'b0; key_restart = 1'b0;
        if (extra && longop) begin
            key_valid = 1'b1; key_restart = 1'b1; key_undo = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            key_valid = 1'b0; key_restart = 1'b0; key_undo = 1'b0;
        end
    endtask

    function automatic logic [133:0] mk_level(input int m, input logic [63:0] walls,
                                              input logic [63:0] boxes);
        return {6'(m), walls, boxes};
    endfunction

    function automatic logic [133:0] rand_level();
        logic [133:0] l;
        int           m;
        l = '0;
        for (int i = 0; i < 64; i++) begin
            l[64 + i] = ($urandom_range(5) == 0);
            l[i] = !l[64 + i] && ($urandom_range(4) == 0);
        end
        m = int'($urandom_range(63));
        l[64 + m] = 1'b0;
        l[m] = 1'b0;
        l[133:128] = 6'(m);
        return l;
    endfunction

    initial begin
        int rn;
        checks = 0; failures = 0;
        rst = 1'b1; key_valid = 1'b0; key_dir = 2'd0; key_undo = 1'b0; key_restart = 1'b0;
        game_state = '0; level = '0; m_state = '0; m_steps = '0;

        do_reset(mk_level(9, 64'd0, 64'd0));
        key(0, 0, 2'b11, 0, 10, 1); wait_idle();
        key(0, 0, 2'b11, 0, 11, 2); wait_idle();
        key(0, 0, 2'b11, 0, -1, -1); wait_idle();
        key(0, 0, 2'b01, 0, 20, 4); wait_idle();
        for (int i = 0; i < 4; i++) begin key(1, 0, 2'b00, 0, -1, -1); wait_idle(); end

        do_reset(mk_level(9, 64'd0, 64'd1 << 10));
        key(0, 0, 2'b11, 0, 10, 1); wait_idle();

        do_reset(mk_level(9, 64'd0, (64'd1 << 10) | (64'd1 << 11)));
        key(0, 0, 2'b11, 0, -1, -1); wait_idle();
        do_reset(mk_level(9, 64'd1 << 11, 64'd1 << 10));
        key(0, 0, 2'b11, 0, -1, -1); wait_idle();
        do_reset(mk_level(15, 64'd0, 64'd0));
        key(0, 0, 2'b11, 0, -1, -1); wait_idle();
        do_reset(mk_level(0, 64'd0, 64'd0));
        key(0, 0, 2'b00, 0, -1, -1); wait_idle();
        key(0, 0, 2'b10, 0, -1, -1); wait_idle();
        do_reset(mk_level(63, 64'd0, 64'd0));
        key(0, 0, 2'b01, 0, -1, -1); wait_idle();

        do_reset(mk_level(27, 64'd0, 64'd0));
        key(0, 0, 2'b01, 1, 35, 1); wait_idle();
        key(1, 0, 2'b00, 1, -1, -1); wait_idle();
        key(0, 0, 2'b10, 0, 26, 1); wait_idle();
        key(1, 1, 2'b00, 0, -1, -1); wait_idle();

        key(0, 0, 2'b11, 0, -1, -1);
        do_reset(mk_level(27, 64'd0, 64'd0));

        for (int lv = 0; lv < 20; lv++) begin
            do_reset(rand_level());
            for (int k = 0; k < 25; k++) begin
                rn = int'($urandom_range(99));
                key(rn >= 8 && rn < 30, rn < 8, 2'($urandom_range(3)),
                    $urandom_range(7) == 0, -1, -1);
                wait_idle();
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
